fma_pack_round: RTL

FMA_PACK_ROUND -- requirements
Module: FMA_pack_round

---
 rtl/fma_pack_round.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fma_pack_round.sv
// fma_pack_round: three-stage carry-save resolve / normalize / round-and-pack to IEEE-754 binary32.
// Build option FMA_PACK_DENORM_EN: tiny results become subnormals instead of flushing to signed zero.
module fma_pack_round #(
    parameter int unsigned LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] csa_sum,
    input  logic [47:0] csa_carry,
    input  logic [9:0]  exp_in,
    input  logic        sign_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        flag_ovf,
    output logic        flag_unf,
    output logic        flag_inexact
);
    localparam int unsigned MAG_W = 48;
    localparam int unsigned EXP_W = 12;
    localparam int unsigned LZC_W = 6;
    localparam int unsigned MAN_W = 24;

    logic                 en;
    logic [LATENCY-1:0]   vld_q, vld_d;

    logic [MAG_W-1:0]     mag1_q, mag1_d;
    logic [9:0]           exp1_q, exp1_d;
    logic                 sign1_q, sign1_d;

    logic [LZC_W-1:0]     lzc;
    logic [MAG_W-1:0]     norm2_q, norm2_d;
    logic [EXP_W-1:0]     e2_q, e2_d;
    logic                 zero2_q, zero2_d;
    logic                 sign2_q, sign2_d;

    logic [MAN_W-1:0]     mant;
    logic                 grd, stk, inc, tiny;
    logic [MAN_W:0]       mant_r;
    logic [EXP_W-1:0]     e_r;
    logic [31:0]          res_q, res_d;
    logic                 ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;

`ifdef FMA_PACK_DENORM_EN
    logic [EXP_W-1:0]     sh;
    logic [MAG_W-1:0]     dn_shf;
    logic                 dn_lost, dn_grd, dn_stk, dn_inc;
    logic [MAN_W-1:0]     dn_mant, dn_mant_r;
`endif

    // Whole pipeline advances together; only a stalled valid output blocks it.
    assign en        = !vld_q[LATENCY-1] || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_q[LATENCY-1];
    assign result       = res_q;
    assign flag_ovf     = ovf_q;
    assign flag_unf     = unf_q;
    assign flag_inexact = inx_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q   <= '0;
            mag1_q  <= '0;
            exp1_q  <= '0;
            sign1_q <= 1'b0;
            norm2_q <= '0;
            e2_q    <= '0;
            zero2_q <= 1'b0;
            sign2_q <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            inx_q   <= 1'b0;
        end else if (en) begin
            vld_q   <= vld_d;
            mag1_q  <= mag1_d;
            exp1_q  <= exp1_d;
            sign1_q <= sign1_d;
            norm2_q <= norm2_d;
            e2_q    <= e2_d;
            zero2_q <= zero2_d;
            sign2_q <= sign2_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            inx_q   <= inx_d;
        end
    end

    // S1: resolve the carry-save pair.
    always_comb begin
        vld_d   = {vld_q[LATENCY-2:0], in_valid};
        mag1_d  = csa_sum + csa_carry;
        exp1_d  = exp_in;
        sign1_d = sign_in;
    end

    // S2: leading-one position, left-justify to bit 47, exponent = exp_in + p - 46.
    always_comb begin
        lzc = LZC_W'(MAG_W - 1);
        for (int i = 0; i < int'(MAG_W); i++) begin
            if (mag1_q[i]) lzc = LZC_W'(int'(MAG_W) - 1 - i);
        end
        norm2_d = mag1_q << lzc;
        e2_d    = {{(EXP_W-10){exp1_q[9]}}, exp1_q} + EXP_W'(1) - EXP_W'(lzc);
        zero2_d = (mag1_q == '0);
        sign2_d = sign1_q;
    end

`ifdef FMA_PACK_DENORM_EN
    // S3 subnormal path: shift right by 1-e, everything shifted out folds into sticky.
    always_comb begin
        sh = EXP_W'(1) - e2_q;
        if (sh >= EXP_W'(MAG_W)) begin
            dn_shf  = '0;
            dn_lost = |norm2_q;
        end else begin
            dn_shf  = norm2_q >> sh[LZC_W-1:0];
            dn_lost = |(norm2_q & ~({MAG_W{1'b1}} << sh[LZC_W-1:0]));
        end
        dn_mant   = dn_shf[MAG_W-1:MAG_W-MAN_W];
        dn_grd    = dn_shf[MAG_W-MAN_W-1];
        dn_stk    = (|dn_shf[MAG_W-MAN_W-2:0]) | dn_lost;
        dn_inc    = dn_grd & (dn_stk | dn_mant[0]);
        dn_mant_r = dn_mant + MAN_W'(dn_inc);
    end
`endif

    // S3: round-to-nearest-even, range checks and packing.
    always_comb begin
        res_d  = res_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        inx_d  = inx_q;
        mant   = norm2_q[MAG_W-1:MAG_W-MAN_W];
        grd    = norm2_q[MAG_W-MAN_W-1];
        stk    = |norm2_q[MAG_W-MAN_W-2:0];
        inc    = grd & (stk | mant[0]);
        mant_r = {1'b0, mant} + (MAN_W+1)'(inc);
        e_r    = mant_r[MAN_W] ? e2_q + EXP_W'(1) : e2_q;
        tiny   = e2_q[EXP_W-1] || (e2_q == '0);
        if (vld_q[1]) begin
            if (zero2_q) begin
                res_d = {sign2_q, 31'b0};
                ovf_d = 1'b0;
                unf_d = 1'b0;
                inx_d = 1'b0;
            end else if (tiny) begin
`ifdef FMA_PACK_DENORM_EN
                // Rounding carry into bit 23 lands naturally in exponent field 1.
                res_d = {sign2_q, 7'b0, dn_mant_r};
                ovf_d = 1'b0;
                inx_d = dn_grd | dn_stk;
                unf_d = (dn_grd | dn_stk) & !dn_mant_r[MAN_W-1];
`else
                res_d = {sign2_q, 31'b0};
                ovf_d = 1'b0;
                unf_d = 1'b1;
                inx_d = 1'b1;
`endif
            end else if (e_r >= EXP_W'(255)) begin
                res_d = {sign2_q, 8'hFF, 23'b0};
                ovf_d = 1'b1;
                unf_d = 1'b0;
                inx_d = 1'b1;
            end else begin
                res_d = {sign2_q, e_r[7:0],
                         mant_r[MAN_W] ? mant_r[MAN_W-1:1] : mant_r[MAN_W-2:0]};
                ovf_d = 1'b0;
                unf_d = 1'b0;
                inx_d = grd | stk;
            end
        end
    end

endmodule
